// File: rtl/gray_hot_decoder.sv
// Decodes 7-bit Gray or one-hot code words to 3-bit binary through a one-stage
// valid/ready register, flagging illegal words and out-of-sequence steps.
module gray_hot_decoder #(
    parameter int unsigned USE_GRAY   = 1,
    parameter int unsigned STEP_CHECK = 1,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       A,
    output logic             code_err,
    output logic             step_err,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        TRACK = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [2:0]       prev_q, prev_d;
    logic [2:0]       a_q, a_d;
    logic             valid_q, valid_d;
    logic             ce_q, ce_d;
    logic             se_q, se_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [2:0]       dec_a;
    logic             dec_legal;
    logic [2:0]       prev_inc;
    logic             accept;

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign prev_inc = prev_q + 3'd1;

    always_comb begin
        dec_a     = '0;
        dec_legal = 1'b0;
        if (USE_GRAY != 0) begin
            dec_legal = (B[6:3] == 4'b0000);
            dec_a     = {B[2], B[2] ^ B[1], B[2] ^ B[1] ^ B[0]};
        end else if (B == '0) begin
            dec_legal = 1'b1;
        end else if ((B & (B - 7'd1)) == '0) begin
            // Single bit k set maps to k+1; zero word is reserved for value 0.
            dec_legal = 1'b1;
            for (int unsigned k = 0; k < 7; k++) begin
                if (B[k]) dec_a = 3'(k + 1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        valid_d = valid_q;
        a_d     = a_q;
        ce_d    = ce_q;
        se_d    = se_q;
        cnt_d   = cnt_q;

        if (accept) begin
            valid_d = 1'b1;
            if (dec_legal) begin
                a_d     = dec_a;
                ce_d    = 1'b0;
                prev_d  = dec_a;
                state_d = TRACK;
                case (state_q)
                    IDLE:    se_d = 1'b0;
                    TRACK:   se_d = (STEP_CHECK != 0) && (dec_a != prev_inc);
                    default: se_d = 1'b0;
                endcase
            end else begin
                a_d  = '0;
                ce_d = 1'b1;
                se_d = 1'b0;
            end
        end else if (out_ready) begin
            valid_d = 1'b0;
        end

        if (clr_cnt) begin
            cnt_d = '0;
        end else if (accept && (ce_d || se_d) && (cnt_q != '1)) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            prev_q  <= '0;
            valid_q <= 1'b0;
            a_q     <= '0;
            ce_q    <= 1'b0;
            se_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            valid_q <= valid_d;
            a_q     <= a_d;
            ce_q    <= ce_d;
            se_q    <= se_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid = valid_q;
    assign A         = a_q;
    assign code_err  = ce_q;
    assign step_err  = se_q;
    assign err_cnt   = cnt_q;

endmodule

// File: tb/tb_gray_hot_decoder.sv
// Bench for gray_hot_decoder: a Gray instance (2-bit counter) and a one-hot
// instance driven from a shared row table, with a scoreboard of expected outputs.
module tb_gray_hot_decoder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       sel = 1'b0;
    logic       in_valid = 1'b0;
    logic [6:0] b = '0;
    logic       ordy = 1'b1;
    logic       clr = 1'b0;

    logic       g_in_ready, g_out_valid, g_ce, g_se;
    logic [2:0] g_A;
    logic [1:0] g_cnt;
    logic       h_in_ready, h_out_valid, h_ce, h_se;
    logic [2:0] h_A;
    logic [7:0] h_cnt;

    gray_hot_decoder #(.USE_GRAY(1), .STEP_CHECK(1), .CNT_W(2)) u_gray (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid && !sel), .in_ready(g_in_ready), .B(b),
        .out_valid(g_out_valid), .out_ready(sel ? 1'b1 : ordy),
        .A(g_A), .code_err(g_ce), .step_err(g_se),
        .clr_cnt(clr && !sel), .err_cnt(g_cnt)
    );

    gray_hot_decoder #(.USE_GRAY(0), .STEP_CHECK(1), .CNT_W(8)) u_hot (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid && sel), .in_ready(h_in_ready), .B(b),
        .out_valid(h_out_valid), .out_ready(sel ? ordy : 1'b1),
        .A(h_A), .code_err(h_ce), .step_err(h_se),
        .clr_cnt(clr && sel), .err_cnt(h_cnt)
    );

    logic       s_in_ready, s_out_valid, s_ce, s_se;
    logic [2:0] s_A;
    logic [7:0] s_cnt;
    assign s_in_ready  = sel ? h_in_ready  : g_in_ready;
    assign s_out_valid = sel ? h_out_valid : g_out_valid;
    assign s_A         = sel ? h_A         : g_A;
    assign s_ce        = sel ? h_ce        : g_ce;
    assign s_se        = sel ? h_se        : g_se;
    assign s_cnt       = sel ? h_cnt       : {6'b0, g_cnt};

    typedef struct {
        logic [2:0] a;
        bit         ce;
        bit         se;
    } exp_t;

    typedef struct {
        bit         sel;
        bit         v;
        logic [6:0] b;
        bit         ordy;
        bit         clr;
        logic [2:0] a;
        bit         ce;
        bit         se;
        int         cnt;
    } row_t;

    row_t rows[$];
    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    task automatic add(input bit s, input bit v, input logic [6:0] bb, input bit o,
                       input bit c, input logic [2:0] a, input bit ce, input bit se,
                       input int cnt);
        row_t r;
        r.sel = s; r.v = v; r.b = bb; r.ordy = o; r.clr = c;
        r.a = a; r.ce = ce; r.se = se; r.cnt = cnt;
        rows.push_back(r);
    endtask

    task automatic apply_row(input row_t r);
        bit   exp_rdy;
        exp_t e;
        @(negedge clk);
        sel = r.sel; in_valid = r.v; b = r.b; ordy = r.ordy; clr = r.clr;
        #1;
        exp_rdy = (sb.size() == 0) || r.ordy;
        chk("in_ready", int'(s_in_ready), int'(exp_rdy));
        chk("out_valid", int'(s_out_valid), int'(sb.size() != 0));
        if (sb.size() != 0) begin
            chk("A", int'(s_A), int'(sb[0].a));
            chk("code_err", int'(s_ce), int'(sb[0].ce));
            chk("step_err", int'(s_se), int'(sb[0].se));
            if (r.ordy) void'(sb.pop_front());
        end
        if (r.v && exp_rdy) begin
            e.a = r.a; e.ce = r.ce; e.se = r.se;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        chk("err_cnt", int'(s_cnt), r.cnt);
    endtask

    task automatic run_rows();
        foreach (rows[i]) apply_row(rows[i]);
        rows.delete();
    endtask

    logic [6:0] gcode [9];

    initial begin
        gcode[0] = 7'b000; gcode[1] = 7'b001; gcode[2] = 7'b011;
        gcode[3] = 7'b010; gcode[4] = 7'b110; gcode[5] = 7'b111;
        gcode[6] = 7'b101; gcode[7] = 7'b100; gcode[8] = 7'b000;

        repeat (2) @(negedge clk);
        chk("rst g out_valid", int'(g_out_valid), 0);
        chk("rst g A", int'(g_A), 0);
        chk("rst g err_cnt", int'(g_cnt), 0);
        chk("rst g in_ready", int'(g_in_ready), 1);
        chk("rst h out_valid", int'(h_out_valid), 0);
        chk("rst h flags", int'({h_ce, h_se}), 0);
        chk("rst h err_cnt", int'(h_cnt), 0);
        rst_n = 1'b1;

        // Gray step check: 0,1,2,5 -> step error on 5, then 6 resynchronised.
        add(0, 1, 7'b000, 1, 0, 3'd0, 0, 0, 0);
        add(0, 1, 7'b001, 1, 0, 3'd1, 0, 0, 0);
        add(0, 1, 7'b011, 1, 0, 3'd2, 0, 0, 0);
        add(0, 1, 7'b111, 1, 0, 3'd5, 0, 1, 1);
        add(0, 1, 7'b101, 1, 0, 3'd6, 0, 0, 1);
        add(0, 1, 7'b100, 1, 0, 3'd7, 0, 0, 1);
        add(0, 0, 7'b000, 1, 1, 3'd0, 0, 0, 0);
        // Full Gray sweep with wrap 7 -> 0 back to 0.
        for (int i = 0; i < 9; i++) add(0, 1, gcode[i], 1, 0, 3'(i % 8), 0, 0, 0);
        add(0, 0, 7'b000, 1, 0, 3'd0, 0, 0, 0);
        // Backpressure: held output, then same-cycle accept on release.
        add(0, 1, 7'b001, 1, 0, 3'd1, 0, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 1, 7'b011, 0, 0, 3'd2, 0, 0, 0);
        add(0, 1, 7'b011, 1, 0, 3'd2, 0, 0, 0);
        add(0, 0, 7'b000, 1, 0, 3'd0, 0, 0, 0);
        // Saturation of the 2-bit counter, then clear racing an error.
        add(0, 1, 7'b0001000, 1, 0, 3'd0, 1, 0, 1);
        add(0, 1, 7'b0010000, 1, 0, 3'd0, 1, 0, 2);
        add(0, 1, 7'b0100000, 1, 0, 3'd0, 1, 0, 3);
        add(0, 1, 7'b1000000, 1, 0, 3'd0, 1, 0, 3);
        add(0, 1, 7'b1111111, 1, 0, 3'd0, 1, 0, 3);
        add(0, 1, 7'b1000001, 1, 1, 3'd0, 1, 0, 0);
        add(0, 0, 7'b000, 1, 0, 3'd0, 0, 0, 0);
        // Illegal words left the tracker at 2, so 3 is in sequence.
        add(0, 1, 7'b010, 1, 0, 3'd3, 0, 0, 0);
        add(0, 0, 7'b000, 1, 0, 3'd0, 0, 0, 0);
        add(0, 1, 7'b110, 0, 0, 3'd4, 0, 0, 0);
        add(0, 0, 7'b000, 0, 0, 3'd0, 0, 0, 0);
        run_rows();

        @(negedge clk);
        in_valid = 1'b0; ordy = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst out_valid", int'(g_out_valid), 0);
        chk("midrst A", int'(g_A), 0);
        chk("midrst in_ready", int'(g_in_ready), 1);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;

        // First word after reset (6 after 4) must not flag a step error.
        add(0, 1, 7'b101, 1, 0, 3'd6, 0, 0, 0);
        add(0, 0, 7'b000, 1, 0, 3'd0, 0, 0, 0);
        // One-hot sweep, illegal words, wrap, then a step error.
        add(1, 1, 7'b0000000, 1, 0, 3'd0, 0, 0, 0);
        for (int k = 0; k < 7; k++) add(1, 1, 7'(1 << k), 1, 0, 3'(k + 1), 0, 0, 0);
        add(1, 1, 7'b0000011, 1, 0, 3'd0, 1, 0, 1);
        add(1, 1, 7'b1100000, 1, 0, 3'd0, 1, 0, 2);
        add(1, 1, 7'b0000000, 1, 0, 3'd0, 0, 0, 2);
        add(1, 1, 7'b0000100, 1, 0, 3'd3, 0, 1, 3);
        add(1, 0, 7'b0000000, 1, 0, 3'd0, 0, 0, 3);
        run_rows();

        chk("scoreboard empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
